// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter: buffers one 24-bit L/R pair, generates sclk/ws, serializes 64-sclk frames.
// Latency: a held pair goes out at the next frame boundary; its left MSB is driven on that boundary edge.
// Backpressure: smpl_rdy is low while the single holding register is full; at most one pair per frame.
module i2s_mstr_tx #(
  parameter int DATA_W   = 24,
  parameter int SCLK_DIV = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data,
  output logic              underrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HALF  = SCLK_DIV / 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [5:0]        bit_q;
  logic [63:0]       sr_q;
  logic              sclk_q;
  logic              ws_q;
  logic              data_q;
  logic              underrun_q;

  logic [DATA_W-1:0] hold_l_q;
  logic [DATA_W-1:0] hold_r_q;
  logic              hold_full_q;
  logic              hold_full_d;
  logic              smpl_rdy_q;

  logic              xfer_w;
  logic              rise_w;
  logic              fall_w;
  logic              bndry_w;
  logic              load_w;
  logic [5:0]        bit_nxt_w;
  logic              ws_nxt_w;
  logic [31:0]       lft_pad_w;
  logic [31:0]       rght_pad_w;
  logic [63:0]       frame_w;

  assign xfer_w    = smpl_vld && smpl_rdy_q;
  assign rise_w    = (state_q == RUN) && (div_q == DIV_W'(HALF - 1));
  assign fall_w    = (state_q == RUN) && (div_q == DIV_W'(SCLK_DIV - 1));
  // Frame boundary: the falling edge that takes bit_cnt from 63 back to 0.
  assign bndry_w   = fall_w && (bit_q == 6'd63);
  assign load_w    = bndry_w && en && hold_full_q;
  assign bit_nxt_w = bit_q + 6'd1;
  // WS goes high one bit before the right MSB and low one bit before the left MSB.
  assign ws_nxt_w  = (bit_nxt_w >= 6'd31) && (bit_nxt_w <= 6'd62);

  // Samples are left-justified in their 32-bit slot; the tail is zero, never sign bits.
  assign lft_pad_w  = 32'(hold_l_q) << (32 - DATA_W);
  assign rght_pad_w = 32'(hold_r_q) << (32 - DATA_W);
  assign frame_w    = hold_full_q ? {lft_pad_w, rght_pad_w} : 64'd0;

  // Holding-register occupancy: a boundary load empties it, an accepted pair fills it.
  always_comb begin
    hold_full_d = hold_full_q;
    if (load_w) begin
      hold_full_d = 1'b0;
    end else if (xfer_w) begin
      hold_full_d = 1'b1;
    end
  end

  // Handshake and single-pair buffer; reset discards whatever was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      smpl_rdy_q  <= 1'b1;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      smpl_rdy_q  <= !hold_full_d;
      if (xfer_w) begin
        hold_l_q <= lft_in;
        hold_r_q <= rght_in;
      end
    end
  end

  // Sequencer: clock divider, bit counter, frame shifter and all serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= 6'd63;
      sr_q       <= 64'd0;
      sclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q  <= '0;
          bit_q  <= 6'd63;
          sclk_q <= 1'b0;
          ws_q   <= 1'b0;
          data_q <= 1'b0;
          if (en) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          div_q <= fall_w ? '0 : div_q + DIV_W'(1);
          if (rise_w) begin
            sclk_q <= 1'b1;
          end
          if (fall_w) begin
            sclk_q <= 1'b0;
            if (bndry_w && !en) begin
              // Stop cleanly: the frame just finished, nothing is loaded and no underrun is flagged.
              state_q <= IDLE;
              ws_q    <= 1'b0;
              data_q  <= 1'b0;
            end else begin
              bit_q <= bit_nxt_w;
              ws_q  <= ws_nxt_w;
              if (bndry_w) begin
                data_q     <= frame_w[63];
                sr_q       <= {frame_w[62:0], 1'b0};
                underrun_q <= !hold_full_q;
              end else begin
                data_q <= sr_q[63];
                sr_q   <= {sr_q[62:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign smpl_rdy = smpl_rdy_q;
  assign I2S_sclk = sclk_q;
  assign I2S_ws   = ws_q;
  assign I2S_data = data_q;
  assign underrun = underrun_q;

endmodule
